onehot_decoder: RTL and testbench
=================================

# onehot_decoder

Handshaked, registered binary-to-one-hot decoder: the receive end of the priority-encoder path. It accepts an index plus a "none" flag, as produced from an encoder's all-zero input, and presents an N-bit one-hot vector. The vector is held for a programmable minimum dwell and retired only on a valid/ready handshake. It drives the core's one-hot select lines (register-file write enables, interrupt acknowledge) from encoded indices.

## Interface
- N, default 16: output vector width; any value ≥ 2, not required to be a power of two.
- HOLD, default 1: minimum cycles the vector is presented before it may retire; must be ≥ 1.
- W, localparam = clog2(N), minimum 1: index width.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- in_valid  in  1  index request present.
- in_ready  out  1  decoder can accept; combinational from state and out_ready.
- in_index  in  W  binary index to decode.
- in_none  in  1  encoder saw no active input; decode to all-zero regardless of in_index.
- out_valid  out  1  out_vec/out_err valid.
- out_ready  in  1  consumer accepts the presented vector.
- out_vec  out  N  one-hot (or all-zero) decoded vector, registered.
- out_err  out  1  presented request had in_index ≥ N (and in_none=0).
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, DWELL, WAIT. Internal dwell counter cnt, width clog2(HOLD)+1.
- Accept = in_valid & in_ready.
- in_ready = !rst & (state==IDLE | (state==WAIT & out_ready)).
- On accept:
  - in_none=1 → out_vec=0, out_err=0.
  - else in_index<N → out_vec=1<<in_index, out_err=0.
  - else → out_vec=0, out_err=1.
  - cnt ← HOLD-1. Next state DWELL if HOLD>1, else WAIT.
- DWELL: cnt decrements each cycle; out_ready ignored; state → WAIT when cnt==1 at the edge, so cnt reaches 0.
- WAIT: out_ready=1 retires the vector.
  - With accept in the same cycle: load the new vector and restart dwell (back-to-back).
  - Otherwise: out_vec←0, out_err←0, state→IDLE.
- out_valid = (state≠IDLE), registered-equivalent. It is never high with a stale vector.
- out_vec/out_err are stable the whole time out_valid is high.
- in_index/in_none are sampled only on accept; changes at other times are ignored.
- Reset mid-operation: the in-flight vector is discarded without handshake. No partial output.

## Timing
- Reset values: state=IDLE, out_valid=0, out_vec=0, out_err=0, busy=0, cnt=0. in_ready=0 while rst=1.
- Latency: accept at edge k → out_valid=1 and out_vec valid from cycle k+1.
- Minimum presentation: HOLD cycles. Earliest retire edge is k+HOLD.
- Throughput: with HOLD=1 and out_ready held high, one request per cycle. Otherwise one per HOLD cycles, minimum.
- out_ready in DWELL: no effect, and in_ready stays 0.
- Simultaneous retire+accept in WAIT: out_valid stays 1 and out_vec switches to the new value at the next edge, with no idle gap.
- Simultaneous rst with anything: rst wins.

## Structure
- Shared package `decoder_pkg`: state enum (IDLE, DWELL, WAIT) and `clog2` function. The same clog2 is reused by encoder blocks.
- Sub-module `bin2onehot` (params N, W): purely combinational index → one-hot vector with range flag. The FSM, counter and output registers live in `onehot_decoder`.
- No other sub-modules.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → in_ready=0, out_valid=0, out_vec=0. First cycle after release → in_ready=1.
- Basic decode: N=16, HOLD=1, in_index=5, out_ready=1 → next cycle out_vec=16'h0020, out_valid=1, out_err=0. IDLE the cycle after.
- None/error: in_none=1, in_index=7 → out_vec=0, out_err=0, out_valid=1. Then with N=12, in_index=13 → out_vec=0, out_err=1.
- Dwell: HOLD=3, out_ready tied 1, in_index=2 accepted at edge 0 → out_vec=0x0004 held for cycles 1-3. in_ready=0 in cycles 1-2. Retire at edge 3.
- Backpressure/back-to-back: HOLD=1, stream indices 0,1,2,3 with out_ready low for 4 cycles after first → out_vec=0x0001 stable and in_ready=0 while stalled. Then 0x0002, 0x0004, 0x0008 on consecutive cycles.
- Reset mid-operation: HOLD=4, assert rst in the 2nd DWELL cycle → next cycle out_valid=0, out_vec=0, state IDLE. A new request decodes normally.

Source files
------------

// File: rtl/onehot_decoder_pkg.sv
// Shared decoder/encoder definitions.
//   state_t : decoder FSM states
//   clog2   : ceil(log2(v)), 0 for v<=1
//   idx_w   : index width for an N-wide vector, never below 1
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/onehot_decoder_if.sv
// Request/response bundle for onehot_decoder.
//   in_valid/in_ready/in_index/in_none : encoded index request
//   out_valid/out_ready/out_vec/out_err : decoded vector response
// slave = decoder side, master = producer/consumer side.
interface onehot_decoder_if
    import decoder_pkg::*;
#(
    parameter int N = 16
);
    localparam int W = idx_w(N);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_index;
    logic         in_none;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_vec;
    logic         out_err;

    modport slave (
        input  in_valid, in_index, in_none, out_ready,
        output in_ready, out_valid, out_vec, out_err
    );

    modport master (
        output in_valid, in_index, in_none, out_ready,
        input  in_ready, out_valid, out_vec, out_err
    );

endinterface

// File: rtl/onehot_decoder_bin2onehot.sv
// Combinational binary index to one-hot vector.
//   index    : binary index
//   vec      : one-hot vector, all-zero when index >= N
//   in_range : index < N
module bin2onehot #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [W-1:0] index,
    output logic [N-1:0] vec,
    output logic         in_range
);

    // Compare against every legal position so that non-power-of-two N
    // naturally flags the unused upper codes as out of range.
    always_comb begin
        vec      = '0;
        in_range = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (index == W'(i)) begin
                vec[i]   = 1'b1;
                in_range = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_decoder.sv
// Handshaked, registered binary-to-one-hot decoder with minimum dwell.
//   clk, rst : clock, synchronous active-high reset
//   bus      : onehot_decoder_if slave (request in, vector out)
//   busy     : FSM not idle
// A vector is presented for at least HOLD cycles, then retired on
// out_valid & out_ready; a new request may be taken on the retire cycle.
module onehot_decoder
    import decoder_pkg::*;
#(
    parameter int N    = 16,
    parameter int HOLD = 1
) (
    input  logic             clk,
    input  logic             rst,
    onehot_decoder_if.slave  bus,
    output logic             busy
);

    localparam int     W       = idx_w(N);
    localparam int     CW      = clog2(HOLD) + 1;
    // With HOLD=1 there is nothing to dwell on, go straight to WAIT.
    localparam state_t LOAD_ST = (HOLD > 1) ? DWELL : WAIT;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    vec_q;
    logic            err_q;
    logic [N-1:0]    dec_vec;
    logic            dec_ok;
    logic            accept;
    logic            retire;

    bin2onehot #(.N(N), .W(W)) u_dec (
        .index    (bus.in_index),
        .vec      (dec_vec),
        .in_range (dec_ok)
    );

    assign accept = bus.in_valid && bus.in_ready;
    assign retire = (state == WAIT) && bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = LOAD_ST;
            // <= 1 rather than == 1 so a corrupted cnt cannot stall here
            DWELL: if (cnt <= CW'(1)) state_nx = WAIT;
            WAIT:  if (bus.out_ready) state_nx = accept ? LOAD_ST : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.in_ready  = !rst && (state == IDLE || (state == WAIT && bus.out_ready));
        bus.out_valid = (state != IDLE);
        busy          = (state != IDLE);
    end

    // Dwell counter and output vector registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            vec_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            cnt   <= CW'(HOLD - 1);
            vec_q <= (bus.in_none || !dec_ok) ? '0 : dec_vec;
            err_q <= !bus.in_none && !dec_ok;
        end else begin
            if (state == DWELL) cnt <= cnt - 1'b1;
            // Clear on retire so out_vec is never left stale in IDLE
            if (retire) begin
                vec_q <= '0;
                err_q <= 1'b0;
            end
        end
    end

    assign bus.out_vec = vec_q;
    assign bus.out_err = err_q;

endmodule

// File: tb/tb_onehot_decoder.sv
// Directed bench for onehot_decoder: four instances (N/HOLD variants)
// with a per-instance scoreboard popped on each retire handshake.
module tb_onehot_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_busy, b_busy, c_busy, d_busy;

    int n_cmp = 0;
    int n_err = 0;

    // {err, vec[15:0]}
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [16:0] qc[$];
    logic [16:0] qd[$];

    always #5 clk = ~clk;

    onehot_decoder_if #(.N(16)) a_if ();
    onehot_decoder_if #(.N(12)) b_if ();
    onehot_decoder_if #(.N(16)) c_if ();
    onehot_decoder_if #(.N(16)) d_if ();

    onehot_decoder #(.N(16), .HOLD(1)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave), .busy(a_busy));
    onehot_decoder #(.N(12), .HOLD(1)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave), .busy(b_busy));
    onehot_decoder #(.N(16), .HOLD(3)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave), .busy(c_busy));
    onehot_decoder #(.N(16), .HOLD(4)) u_d (.clk(clk), .rst(rst), .bus(d_if.slave), .busy(d_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard monitors: a retire happens when a valid vector meets
    // out_ready in WAIT, which is exactly when in_ready is also high.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst && a_if.out_valid && a_if.out_ready && a_if.in_ready) begin
            if (qa.size() == 0) chk("a_sb_empty", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_sb_vec", 32'(a_if.out_vec), 32'(e[15:0]));
                chk("a_sb_err", 32'(a_if.out_err), 32'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst && b_if.out_valid && b_if.out_ready && b_if.in_ready) begin
            if (qb.size() == 0) chk("b_sb_empty", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_sb_vec", 32'(b_if.out_vec), 32'(e[15:0]));
                chk("b_sb_err", 32'(b_if.out_err), 32'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst && c_if.out_valid && c_if.out_ready && c_if.in_ready) begin
            if (qc.size() == 0) chk("c_sb_empty", 32'd1, 32'd0);
            else begin
                e = qc.pop_front();
                chk("c_sb_vec", 32'(c_if.out_vec), 32'(e[15:0]));
                chk("c_sb_err", 32'(c_if.out_err), 32'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst && d_if.out_valid && d_if.out_ready && d_if.in_ready) begin
            if (qd.size() == 0) chk("d_sb_empty", 32'd1, 32'd0);
            else begin
                e = qd.pop_front();
                chk("d_sb_vec", 32'(d_if.out_vec), 32'(e[15:0]));
                chk("d_sb_err", 32'(d_if.out_err), 32'(e[16]));
            end
        end
    end

    initial begin
        a_if.in_valid = 0; a_if.in_index = '0; a_if.in_none = 0; a_if.out_ready = 0;
        b_if.in_valid = 0; b_if.in_index = '0; b_if.in_none = 0; b_if.out_ready = 0;
        c_if.in_valid = 0; c_if.in_index = '0; c_if.in_none = 0; c_if.out_ready = 0;
        d_if.in_valid = 0; d_if.in_index = '0; d_if.in_none = 0; d_if.out_ready = 0;

        // Reset held 3 cycles with a pending request
        a_if.in_valid = 1; a_if.in_index = 4'd5;
        repeat (3) begin
            smp();
            chk("rst_in_ready",  32'(a_if.in_ready),  32'd0);
            chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
            chk("rst_out_vec",   32'(a_if.out_vec),   32'd0);
            chk("rst_busy",      32'(a_busy),         32'd0);
        end
        cyc(); rst = 0; a_if.in_valid = 0;
        smp();
        chk("rel_in_ready", 32'(a_if.in_ready), 32'd1);

        // Basic decode, index 5
        cyc(); a_if.in_valid = 1; a_if.in_index = 4'd5; a_if.out_ready = 1;
        qa.push_back({1'b0, 16'h0020});
        cyc(); a_if.in_valid = 0;
        smp();
        chk("basic_valid", 32'(a_if.out_valid), 32'd1);
        chk("basic_vec",   32'(a_if.out_vec),   32'h0020);
        chk("basic_err",   32'(a_if.out_err),   32'd0);
        cyc(); smp();
        chk("basic_idle_valid", 32'(a_if.out_valid), 32'd0);
        chk("basic_idle_busy",  32'(a_busy),         32'd0);
        chk("basic_idle_vec",   32'(a_if.out_vec),   32'd0);

        // in_none overrides the index
        cyc(); a_if.in_valid = 1; a_if.in_none = 1; a_if.in_index = 4'd7; a_if.out_ready = 0;
        qa.push_back({1'b0, 16'h0000});
        cyc(); a_if.in_valid = 0; a_if.in_none = 0;
        smp();
        chk("none_valid", 32'(a_if.out_valid), 32'd1);
        chk("none_vec",   32'(a_if.out_vec),   32'd0);
        chk("none_err",   32'(a_if.out_err),   32'd0);
        cyc(); a_if.out_ready = 1;
        cyc(); smp();
        chk("none_idle", 32'(a_if.out_valid), 32'd0);

        // Out-of-range index on N=12, then the top legal index and first illegal one back-to-back
        cyc(); b_if.in_valid = 1; b_if.in_index = 4'd13; b_if.out_ready = 1;
        qb.push_back({1'b1, 16'h0000});
        cyc(); b_if.in_valid = 0;
        smp();
        chk("err_valid", 32'(b_if.out_valid), 32'd1);
        chk("err_vec",   32'(b_if.out_vec),   32'd0);
        chk("err_err",   32'(b_if.out_err),   32'd1);
        cyc(); b_if.in_valid = 1; b_if.in_index = 4'd11;
        qb.push_back({1'b0, 16'h0800});
        cyc(); b_if.in_index = 4'd12;
        qb.push_back({1'b1, 16'h0000});
        smp();
        chk("b11_vec", 32'(b_if.out_vec), 32'h0800);
        cyc(); b_if.in_valid = 0;
        smp();
        chk("b12_err", 32'(b_if.out_err), 32'd1);
        chk("b12_vec", 32'(b_if.out_vec), 32'd0);
        cyc(); smp();
        chk("b_idle", 32'(b_if.out_valid), 32'd0);

        // Dwell, HOLD=3; index changes while dwelling must be ignored
        cyc(); c_if.in_valid = 1; c_if.in_index = 4'd2; c_if.out_ready = 1;
        qc.push_back({1'b0, 16'h0004});
        cyc(); c_if.in_valid = 0; c_if.in_index = 4'd9;
        for (int i = 1; i <= 3; i++) begin
            smp();
            chk("dwell_valid", 32'(c_if.out_valid), 32'd1);
            chk("dwell_vec",   32'(c_if.out_vec),   32'h0004);
            chk("dwell_in_ready", 32'(c_if.in_ready), (i == 3) ? 32'd1 : 32'd0);
            cyc();
        end
        smp();
        chk("dwell_idle", 32'(c_if.out_valid), 32'd0);

        // Backpressure then back-to-back stream 0..3
        cyc(); a_if.in_valid = 1; a_if.in_index = 4'd0; a_if.out_ready = 0;
        qa.push_back({1'b0, 16'h0001});
        qa.push_back({1'b0, 16'h0002});
        qa.push_back({1'b0, 16'h0004});
        qa.push_back({1'b0, 16'h0008});
        cyc(); a_if.in_index = 4'd1;
        repeat (4) begin
            smp();
            chk("stall_vec",      32'(a_if.out_vec),   32'h0001);
            chk("stall_in_ready", 32'(a_if.in_ready),  32'd0);
            chk("stall_valid",    32'(a_if.out_valid), 32'd1);
            cyc();
        end
        a_if.out_ready = 1;
        smp();
        chk("b2b_vec0", 32'(a_if.out_vec), 32'h0001);
        cyc(); a_if.in_index = 4'd2;
        smp();
        chk("b2b_vec1", 32'(a_if.out_vec), 32'h0002);
        cyc(); a_if.in_index = 4'd3;
        smp();
        chk("b2b_vec2", 32'(a_if.out_vec), 32'h0004);
        cyc(); a_if.in_valid = 0;
        smp();
        chk("b2b_vec3",  32'(a_if.out_vec),   32'h0008);
        chk("b2b_valid", 32'(a_if.out_valid), 32'd1);
        cyc(); smp();
        chk("b2b_idle", 32'(a_if.out_valid), 32'd0);

        // Reset in the second dwell cycle discards the vector
        cyc(); d_if.in_valid = 1; d_if.in_index = 4'd3; d_if.out_ready = 1;
        cyc(); d_if.in_valid = 0;
        smp();
        chk("mid_vec_pre", 32'(d_if.out_vec), 32'h0008);
        cyc(); rst = 1;
        smp();
        chk("mid_in_ready_rst", 32'(d_if.in_ready), 32'd0);
        cyc(); rst = 0;
        smp();
        chk("mid_valid", 32'(d_if.out_valid), 32'd0);
        chk("mid_vec",   32'(d_if.out_vec),   32'd0);
        chk("mid_busy",  32'(d_busy),         32'd0);
        cyc(); d_if.in_valid = 1; d_if.in_index = 4'd6;
        qd.push_back({1'b0, 16'h0040});
        cyc(); d_if.in_valid = 0;
        smp();
        chk("post_vec", 32'(d_if.out_vec), 32'h0040);
        repeat (4) cyc();
        smp();
        chk("post_idle", 32'(d_if.out_valid), 32'd0);

        // Every expected vector must have been retired
        chk("qa_left", 32'(qa.size()), 32'd0);
        chk("qb_left", 32'(qb.size()), 32'd0);
        chk("qc_left", 32'(qc.size()), 32'd0);
        chk("qd_left", 32'(qd.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
